// File: rtl/generador_rot.sv
// generador_rot: quadrature rotary-encoder emulator.
//
// Turns single-cycle UP / DOWN requests into clockwise / counter-clockwise
// detent steps on ROTA/ROTB. It also turns ENTER into a fixed-length
// push-button press on ROTC. Step requests are buffered in a signed pending
// count (-15..+15), so a burst of requests is emitted as back-to-back detents.
//
// Ports
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   UP     in   one clockwise detent request (single cycle)
//   DOWN   in   one counter-clockwise detent request (single cycle)
//   ENTER  in   one button press request (single cycle)
//   ROTA   out  encoder channel A (registered)
//   ROTB   out  encoder channel B (registered)
//   ROTC   out  button level (registered)
//   BUSY   out  step engine active or steps still pending
//   OVF    out  one-cycle pulse when a request hit the pending-count limit
//
// Step engine states
//   state | meaning
//   IDLE  | no step in progress, A/B = 00
//   PH1   | first quarter: CW 10, CCW 01
//   PH2   | second quarter: 11
//   PH3   | third quarter: CW 01, CCW 10
//   GAP   | detent rest: 00

module generador_rot #(
    parameter int unsigned STEP_CYCLES  = 50000,
    parameter int unsigned PRESS_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic UP,
    input  logic DOWN,
    input  logic ENTER,
    output logic ROTA,
    output logic ROTB,
    output logic ROTC,
    output logic BUSY,
    output logic OVF
);

    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

    localparam logic [19:0]        STEP_LOAD  = 20'(STEP_CYCLES - 1);
    localparam logic [19:0]        PRESS_LOAD = 20'(PRESS_CYCLES - 1);
    localparam logic signed [4:0]  PEND_MAX   = 5'sd15;
    localparam logic signed [4:0]  PEND_MIN   = -5'sd15;
    localparam logic signed [4:0]  ONE        = 5'sd1;
    localparam logic signed [4:0]  MINUS_ONE  = -5'sd1;

    state_t             state_q, state_d;
    logic               dir_q, dir_d;        // 1 = clockwise
    logic [19:0]        phase_q, phase_d;
    logic signed [4:0]  pend_q, pend_d;
    logic [19:0]        press_q, press_d;
    logic               rota_d, rotb_d, rotc_d, ovf_d;

    logic               req_up, req_dn, drop_up, drop_dn;
    logic signed [4:0]  step_adj, req_adj;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            phase_q <= '0;
            pend_q  <= '0;
            press_q <= '0;
            ROTA    <= 1'b0;
            ROTB    <= 1'b0;
            ROTC    <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            press_q <= press_d;
            ROTA    <= rota_d;
            ROTB    <= rotb_d;
            ROTC    <= rotc_d;
            OVF     <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        phase_d  = phase_q;
        step_adj = '0;
        req_adj  = '0;
        rota_d   = 1'b0;
        rotb_d   = 1'b0;
        rotc_d   = ROTC;
        press_d  = press_q;

        // Step engine: each non-idle phase holds for STEP_CYCLES cycles.
        unique case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    state_d  = PH1;
                    dir_d    = ~pend_q[4];
                    phase_d  = STEP_LOAD;
                    step_adj = pend_q[4] ? ONE : MINUS_ONE;
                end
            end
            PH1, PH2, PH3, GAP: begin
                if (phase_q == '0) begin
                    phase_d = STEP_LOAD;
                    case (state_q)
                        PH1:     state_d = PH2;
                        PH2:     state_d = PH3;
                        PH3:     state_d = GAP;
                        default: begin
                            state_d = IDLE;
                            phase_d = '0;
                        end
                    endcase
                end else begin
                    phase_d = phase_q - 20'd1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        // Outputs are registered from the current phase, so they trail the
        // state register by one cycle.
        case (state_q)
            PH1: begin
                rota_d = dir_q;
                rotb_d = ~dir_q;
            end
            PH2: begin
                rota_d = 1'b1;
                rotb_d = 1'b1;
            end
            PH3: begin
                rota_d = ~dir_q;
                rotb_d = dir_q;
            end
            default: begin
                rota_d = 1'b0;
                rotb_d = 1'b0;
            end
        endcase

        // Saturation is judged against the count before this edge's adjustment.
        req_up  = UP & ~DOWN;
        req_dn  = DOWN & ~UP;
        drop_up = req_up && (pend_q == PEND_MAX);
        drop_dn = req_dn && (pend_q == PEND_MIN);
        if (req_up && !drop_up) req_adj = ONE;
        if (req_dn && !drop_dn) req_adj = MINUS_ONE;
        pend_d = pend_q + step_adj + req_adj;
        ovf_d  = drop_up | drop_dn;

        // Press engine: ENTER is only honoured while the button is released.
        if (!ROTC) begin
            if (ENTER) begin
                rotc_d  = 1'b1;
                press_d = PRESS_LOAD;
            end
        end else if (press_q == '0) begin
            rotc_d = 1'b0;
        end else begin
            press_d = press_q - 20'd1;
        end
    end

    assign BUSY = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_generador_rot.sv
// Bench for generador_rot. A timeline model predicts every output after every
// clock edge from step start times and press start times. The stimulus process
// pushes the prediction and a monitor pops it and checks it after each edge.
// A small quadrature decoder counts emitted detents. Its counts are compared
// with the number of steps the model started.

module tb_generador_rot;

    localparam int S = 4;
    localparam int P = 6;

    logic CLK = 1'b0;
    logic RST_N, UP, DOWN, ENTER;
    logic ROTA, ROTB, ROTC, BUSY, OVF;

    generador_rot #(.STEP_CYCLES(S), .PRESS_CYCLES(P)) dut (
        .CLK(CLK), .RST_N(RST_N), .UP(UP), .DOWN(DOWN), .ENTER(ENTER),
        .ROTA(ROTA), .ROTB(ROTB), .ROTC(ROTC), .BUSY(BUSY), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model state: edge index, pending count, step start edge, direction,
    // and press start edge.
    int k = 0;
    int m_pend = 0;
    int m_s = -1000;
    int m_ps = -1000;
    bit m_dir = 1'b0;
    int m_cw = 0, m_ccw = 0, mcw_b = 0, mccw_b = 0;

    logic [4:0] q[$];     // {a, b, c, busy, ovf}
    logic [4:0] mon_exp, mon_act;

    int cw_seen = 0, ccw_seen = 0, cw_b = 0, ccw_b = 0;

    always @(posedge ROTA) begin
        if (RST_N) begin
            if (ROTB) ccw_seen++;
            else cw_seen++;
        end
    end

    always @(posedge CLK) begin
        #1;
        if (q.size() > 0) begin
            mon_exp = q.pop_front();
            mon_act = {ROTA, ROTB, ROTC, BUSY, OVF};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL outputs edge_t=%0t abcbo got=%b want=%b", $time, mon_act, mon_exp);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic bit in_win(input int rel, input int len);
        return (rel >= 0) && (rel < len);
    endfunction

    // Predict outputs after the edge that is about to come.
    task automatic model_edge(input bit u, input bit d, input bit e);
        bit idle, drop, rotc_old, a, b, c, busy;
        int new_pend, rel, ph;
        idle     = !in_win(k - 1 - m_s, 4 * S);
        rotc_old = in_win(k - 1 - m_ps, P);
        drop     = 1'b0;
        new_pend = m_pend;
        if (idle && m_pend != 0) begin
            m_s   = k;
            m_dir = (m_pend > 0);
            if (m_dir) begin
                m_cw++;
                new_pend -= 1;
            end else begin
                m_ccw++;
                new_pend += 1;
            end
        end
        if (u && !d) begin
            if (m_pend == 15) drop = 1'b1;
            else new_pend += 1;
        end
        if (d && !u) begin
            if (m_pend == -15) drop = 1'b1;
            else new_pend -= 1;
        end
        m_pend = new_pend;
        if (!rotc_old && e) m_ps = k;
        rel = k - 1 - m_s;
        a = 1'b0;
        b = 1'b0;
        if (in_win(rel, 4 * S)) begin
            ph = rel / S;
            if (m_dir) begin
                a = (ph == 0 || ph == 1);
                b = (ph == 1 || ph == 2);
            end else begin
                a = (ph == 1 || ph == 2);
                b = (ph == 0 || ph == 1);
            end
        end
        busy = in_win(k - m_s, 4 * S) || (m_pend != 0);
        c    = in_win(k - m_ps, P);
        q.push_back({a, b, c, busy, drop});
        k++;
    endtask

    task automatic tick(input bit u, input bit d, input bit e);
        @(negedge CLK);
        UP = u;
        DOWN = d;
        ENTER = e;
        model_edge(u, d, e);
    endtask

    function automatic bit model_busy();
        return (m_pend != 0) || in_win(k - 1 - m_s, 4 * S) || in_win(k - 1 - m_ps, P);
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (model_busy() && n < 500) begin
            tick(0, 0, 0);
            n++;
        end
        check({name, "_drain_bound"}, int'(model_busy()), 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
    endtask

    task automatic rebase();
        cw_b = cw_seen;
        ccw_b = ccw_seen;
        mcw_b = m_cw;
        mccw_b = m_ccw;
    endtask

    task automatic check_dec(input string name);
        check({name, "_cw_detents"}, cw_seen - cw_b, m_cw - mcw_b);
        check({name, "_ccw_detents"}, ccw_seen - ccw_b, m_ccw - mccw_b);
        rebase();
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, then release and
    // optionally issue UP on the first active edge.
    task automatic do_reset(input string name, input bit u);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check({name, "_abc"}, int'({ROTA, ROTB, ROTC}), 0);
        check({name, "_busy"}, int'(BUSY), 0);
        check({name, "_ovf"}, int'(OVF), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        UP = u;
        DOWN = 1'b0;
        ENTER = 1'b0;
        m_pend = 0;
        m_s = -1000;
        m_ps = -1000;
        rebase();
        model_edge(u, 0, 0);
    endtask

    initial begin
        int r;
        RST_N = 1'b0;
        UP = 1'b0;
        DOWN = 1'b0;
        ENTER = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_abc", int'({ROTA, ROTB, ROTC}), 0);
        check("reset_busy_ovf", int'({BUSY, OVF}), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        model_edge(0, 0, 0);

        // single UP, single DOWN
        tick(1, 0, 0);
        wait_idle("single_up");
        check_dec("single_up");
        tick(0, 1, 0);
        wait_idle("single_down");
        check_dec("single_down");

        // three UP, then a DOWN during the first step
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        tick(0, 1, 0);
        wait_idle("up3_down1");
        check("up3_down1_pend", m_pend, 0);
        check_dec("up3_down1");

        // UP and DOWN together: no change
        tick(1, 1, 0);
        wait_idle("both");
        check_dec("both");

        // saturation burst
        for (int i = 0; i < 20; i++) tick(1, 0, 0);
        wait_idle("sat_up");
        check_dec("sat_up");
        for (int i = 0; i < 20; i++) tick(0, 1, 0);
        wait_idle("sat_down");
        check_dec("sat_down");

        // double ENTER with a concurrent UP step
        tick(1, 0, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 1);
        wait_idle("press");
        check_dec("press");

        // reset in PH2 of a CW step with two steps pending
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        do_reset("rst_mid", 1'b0);
        for (int i = 0; i < 30; i++) tick(0, 0, 0);
        check_dec("rst_mid");

        // request on the first edge after reset release is accepted
        tick(0, 0, 1);
        do_reset("rst_first", 1'b1);
        wait_idle("rst_first");
        check_dec("rst_first");

        // randomized traffic: an UP-heavy phase, then a DOWN-heavy phase
        for (int seg = 0; seg < 2; seg++) begin
            for (int i = 0; i < 800; i++) begin
                r = int'($urandom_range(0, 15));
                if (seg == 0)
                    tick(r < 6 || r == 9, r == 6 || r == 9, $urandom_range(0, 19) == 0);
                else
                    tick(r == 0 || r == 9, (r >= 1 && r < 6) || r == 9, $urandom_range(0, 19) == 0);
            end
            wait_idle("random");
            check_dec("random");
        end

        tick(0, 0, 0);
        @(posedge CLK);
        #2;
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
